serial_tx_fifo: RTL and testbench
=================================

// Module: serial_tx_fifo
// PURPOSE
//   Memory-mapped serial transmitter for CPU console output: the data-side
//   peripheral behind the MMU serial select. CPU stores push bytes into a FIFO;
//   an 8N1 UART engine drains the FIFO onto serial line tx.
//   Status word is readable for polling (busy/full/empty/overflow).
// PARAMETERS
//   CLKS_PER_BIT  434  clock cycles per serial bit (>=2; 50 MHz / 115200 ~= 434)
//   DEPTH         16   FIFO entries, power of two, >=2
// PORTS
//   clock   in   1   system clock, all logic on rising edge
//   reset   in   1   synchronous, active-high
//   sel     in   1   MMU select for this peripheral
//   we      in   1   data-bus write enable
//   re      in   1   data-bus read enable
//   addr    in   4   byte offset: 0x0 DATA, 0x4 CTRL/STATUS
//   din     in   32  write data
//   dout    out  32  status word, combinational from registers
//   tx      out  1   serial line, idle high, registered
// BEHAVIOUR
// - Reset (clock edge with reset=1): FIFO empty, rd/wr ptrs=0, count=0,
//   state=IDLE, tx=1, overflow=0, baud counter=0, bit index=0. Applies mid-frame:
//   frame aborted, tx=1 after that edge, queued bytes discarded.
// - dout = {28'b0, overflow, full, empty, busy}; busy = (state!=IDLE)|~empty.
//   Same value for any addr; re has no side effects.
// - Push: sel&we&addr==0x0 -> din[7:0] enqueued at that edge. Accepted iff
//   count<DEPTH OR a pop occurs on the same edge. Otherwise byte dropped and
//   overflow<=1 (sticky).
// - CTRL write: sel&we&addr==0x4 with din[0]=1 -> overflow<=0. If a drop and a
//   clear occur on the same edge, clear wins... not possible (different addr).
// - count arithmetic: count' = count + push_acc - pop; width clog2(DEPTH)+1.
//   Pointers wrap modulo DEPTH.
// - FSM states: IDLE, START, DATA, STOP.
//   IDLE : if count>0 -> pop head into shift reg, tx<=0, baud_cnt<=0, ->START.
//          Else tx<=1.
//   START: hold tx=0 CLKS_PER_BIT cycles; at end tx<=shift[0], bit_idx<=0, ->DATA.
//   DATA : each bit held CLKS_PER_BIT cycles, LSB first; after bit 7
//          tx<=1, ->STOP.
//   STOP : hold tx=1 CLKS_PER_BIT cycles; at end, if count>0 pop next byte,
//          tx<=0, ->START directly (no idle gap); else ->IDLE.
// - Latency: byte pushed into empty FIFO with FSM IDLE on edge E0 -> pop and
//   tx=0 after edge E1. Frame = exactly 10*CLKS_PER_BIT cycles of tx.
// - Back-to-back frames contiguous: stop bit end is immediately next start bit.
// - baud_cnt counts 0..CLKS_PER_BIT-1, bit boundary when baud_cnt==CLKS_PER_BIT-1.
// TESTING (CLKS_PER_BIT=4, DEPTH=16)
// 1. Reset then idle 50 cycles -> tx=1 throughout, dout=0x2 (empty only).
// 2. Write 0x55 to DATA at E0 -> tx low from E1 for 4 cycles, then bits
//    1,0,1,0,1,0,1,0 x4 cycles each, stop 1 x4; total 40 cycles; dout back to 0x2.
// 3. Write 0xA5 then 0x3C on consecutive cycles -> two 40-cycle frames
//    contiguous, no idle cycle between stop of 0xA5 and start of 0x3C.
// 4. 18 back-to-back DATA writes from idle -> first 17 transmitted in order,
//    18th dropped; dout bit3 (overflow)=1, full=1 after write 17.
// 5. Overflow set, write CTRL din=1 -> dout bit3=0 next cycle; FIFO contents intact.
// 6. Assert reset 12 cycles into a frame with 3 bytes queued -> tx=1 next edge,
//    dout=0x2, no further frames emitted.

Source files
------------

// File: rtl/serial_tx_fifo.sv
// Memory-mapped console transmitter: CPU stores fill a byte FIFO that an 8N1 UART
// engine drains onto tx; a status word exposes busy/full/empty/overflow for polling.
module serial_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DEPTH        = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic        re,
    input  logic [3:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        tx
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [BAUD_W-1:0]  baud_cnt, baud_nxt;
    logic [2:0]         bit_idx, bit_nxt;
    logic [7:0]         shift, shift_nxt;
    logic               tx_nxt;

    logic [7:0]         mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
    logic [CNT_W-1:0]   count, count_nxt;
    logic               overflow, overflow_nxt;

    logic               push_req, push_acc, ctrl_wr, pop;
    logic               empty, full, busy, baud_end;
    logic               unused_bits;

    // Bus decode and status flags
    assign push_req = sel & we & (addr == 4'h0);
    assign ctrl_wr  = sel & we & (addr == 4'h4);
    assign empty    = (count == CNT_W'(0));
    assign full     = (count == CNT_W'(DEPTH));
    assign busy     = (state != IDLE) | ~empty;
    assign baud_end = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign dout     = {28'b0, overflow, full, empty, busy};

    // Reads are side-effect free and only the low data byte is stored
    assign unused_bits = ^{re, din[31:8]};

    // UART framing: next-state and datapath updates
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_end ? BAUD_W'(0) : baud_cnt + BAUD_W'(1);
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        tx_nxt    = tx;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                baud_nxt = BAUD_W'(0);
                if (!empty) begin
                    pop       = 1'b1;
                    shift_nxt = mem[rd_ptr];
                    tx_nxt    = 1'b0;
                    state_nxt = START;
                end else begin
                    tx_nxt = 1'b1;
                end
            end
            START: begin
                if (baud_end) begin
                    tx_nxt    = shift[0];
                    bit_nxt   = 3'd0;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (baud_end) begin
                    if (bit_idx == 3'd7) begin
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
                    end else begin
                        tx_nxt    = shift[1];
                        shift_nxt = {1'b0, shift[7:1]};
                        bit_nxt   = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_end) begin
                    // Chain straight into the next start bit when more data waits
                    if (!empty) begin
                        pop       = 1'b1;
                        shift_nxt = mem[rd_ptr];
                        tx_nxt    = 1'b0;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    // FIFO bookkeeping; a pop on the same edge frees the slot a full push needs
    always_comb begin
        push_acc     = push_req & (~full | pop);
        wr_ptr_nxt   = wr_ptr + PTR_W'(push_acc);
        rd_ptr_nxt   = rd_ptr + PTR_W'(pop);
        count_nxt    = count + CNT_W'(push_acc) - CNT_W'(pop);
        overflow_nxt = overflow;
        if (push_req && !push_acc) begin
            overflow_nxt = 1'b1;
        end else if (ctrl_wr && din[0]) begin
            overflow_nxt = 1'b0;
        end
    end

    // FSM state and serial datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= BAUD_W'(0);
            bit_idx  <= 3'd0;
            shift    <= 8'd0;
            tx       <= 1'b1;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            shift    <= shift_nxt;
            tx       <= tx_nxt;
        end
    end

    // FIFO control registers
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr   <= PTR_W'(0);
            wr_ptr   <= PTR_W'(0);
            count    <= CNT_W'(0);
            overflow <= 1'b0;
        end else begin
            rd_ptr   <= rd_ptr_nxt;
            wr_ptr   <= wr_ptr_nxt;
            count    <= count_nxt;
            overflow <= overflow_nxt;
        end
    end

    // FIFO storage, no reset needed: contents are qualified by count
    always_ff @(posedge clock) begin
        if (push_acc) begin
            mem[wr_ptr] <= din[7:0];
        end
    end

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Directed bench for serial_tx_fifo: idle/reset state, single and chained frames,
// FIFO overflow and clear, and reset during an active frame.
module tb_serial_tx_fifo;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned FRAME = 10 * CPB;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sel   = 1'b0;
    logic        we    = 1'b0;
    logic        re    = 1'b0;
    logic [3:0]  addr  = 4'h0;
    logic [31:0] din   = 32'h0;
    wire  [31:0] dout;
    wire         tx;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic cap [0:4095];

    serial_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .sel   (sel),
        .we    (we),
        .re    (re),
        .addr  (addr),
        .din   (din),
        .dout  (dout),
        .tx    (tx)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // tx history, indexed by the number of rising edges seen so far
    always @(negedge clock) if (cyc < 4096) cap[cyc] = tx;

    // Expected line level k cycles into an 8N1 frame carrying b
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        int s;
        s = k / CPB;
        if (s == 0) return 1'b0;
        if (s == 9) return 1'b1;
        return b[s-1];
    endfunction

    task automatic drive_wr(input logic [3:0] a, input logic [31:0] d);
        sel  = 1'b1;
        we   = 1'b1;
        addr = a;
        din  = d;
        @(negedge clock);
    endtask

    task automatic bus_idle;
        sel  = 1'b0;
        we   = 1'b0;
        re   = 1'b0;
        addr = 4'h0;
        din  = 32'h0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        // unselected writes and reads must not disturb anything
        sel  = 1'b0;
        we   = 1'b1;
        re   = 1'b1;
        addr = 4'h0;
        din  = 32'hFF;
        for (int i = 0; i < 50; i++) begin
            addr = (i % 2 == 0) ? 4'h4 : 4'h0;
            @(negedge clock);
            total++;
            if (tx !== 1'b1) begin
                bad++;
                $display("FAIL reset_tx cyc=%0d tx=%b want 1", i, tx);
            end
            total++;
            if (dout !== 32'h2) begin
                bad++;
                $display("FAIL reset_dout cyc=%0d dout=%h want 00000002", i, dout);
            end
        end
        bus_idle();
    endtask

    task automatic test_single_frame;
        drive_wr(4'h0, 32'h0000_0055);
        bus_idle();
        total++;
        if (dout !== 32'h1) begin
            bad++;
            $display("FAIL single_queued dout=%h want 00000001", dout);
        end
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clock);
            total++;
            if (tx !== frame_bit(8'h55, k)) begin
                bad++;
                $display("FAIL single_bit k=%0d tx=%b want %b", k, tx, frame_bit(8'h55, k));
            end
        end
        @(negedge clock);
        total++;
        if (dout !== 32'h2 || tx !== 1'b1) begin
            bad++;
            $display("FAIL single_done dout=%h tx=%b want 00000002 1", dout, tx);
        end
    endtask

    task automatic test_back_to_back;
        logic exp;
        drive_wr(4'h0, 32'h0000_00A5);
        drive_wr(4'h0, 32'h0000_003C);
        bus_idle();
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (k > 0) @(negedge clock);
            exp = (k < FRAME) ? frame_bit(8'hA5, k) : frame_bit(8'h3C, k - FRAME);
            total++;
            if (tx !== exp) begin
                bad++;
                $display("FAIL b2b_bit k=%0d tx=%b want %b", k, tx, exp);
            end
        end
        @(negedge clock);
        total++;
        if (dout !== 32'h2 || tx !== 1'b1) begin
            bad++;
            $display("FAIL b2b_done dout=%h tx=%b want 00000002 1", dout, tx);
        end
    endtask

    task automatic test_overflow;
        int c0;
        logic [7:0] b;
        c0 = 0;
        for (int i = 0; i < 18; i++) begin
            drive_wr(4'h0, 32'(8'h30 + i));
            if (i == 0) c0 = cyc;
            if (i == 16) begin
                total++;
                if (dout !== 32'h5) begin
                    bad++;
                    $display("FAIL ovf_full dout=%h want 00000005", dout);
                end
            end
            if (i == 17) begin
                total++;
                if (dout !== 32'hD) begin
                    bad++;
                    $display("FAIL ovf_set dout=%h want 0000000d", dout);
                end
            end
        end
        drive_wr(4'h4, 32'h1);
        bus_idle();
        total++;
        if (dout !== 32'h5) begin
            bad++;
            $display("FAIL ovf_clear dout=%h want 00000005", dout);
        end
        repeat (17 * FRAME + 10) @(negedge clock);
        for (int j = 0; j < 17; j++) begin
            b = 8'(8'h30 + j);
            for (int k = 0; k < FRAME; k++) begin
                total++;
                if (cap[c0 + 1 + j * FRAME + k] !== frame_bit(b, k)) begin
                    bad++;
                    $display("FAIL ovf_frame byte=%0d k=%0d tx=%b want %b",
                             j, k, cap[c0 + 1 + j * FRAME + k], frame_bit(b, k));
                end
            end
        end
        for (int k = 0; k < 8; k++) begin
            total++;
            if (cap[c0 + 1 + 17 * FRAME + k] !== 1'b1) begin
                bad++;
                $display("FAIL ovf_dropped k=%0d tx=%b want 1", k, cap[c0 + 1 + 17 * FRAME + k]);
            end
        end
        total++;
        if (dout !== 32'h2) begin
            bad++;
            $display("FAIL ovf_drained dout=%h want 00000002", dout);
        end
    endtask

    task automatic test_reset_midframe;
        drive_wr(4'h0, 32'h0000_00FD);
        drive_wr(4'h0, 32'h0000_0011);
        drive_wr(4'h0, 32'h0000_0022);
        drive_wr(4'h0, 32'h0000_0033);
        bus_idle();
        repeat (9) @(negedge clock);
        total++;
        if (tx !== frame_bit(8'hFD, 11) || dout !== 32'h1) begin
            bad++;
            $display("FAIL mid_running tx=%b dout=%h want %b 00000001", tx, dout, frame_bit(8'hFD, 11));
        end
        reset = 1'b1;
        @(negedge clock);
        total++;
        if (tx !== 1'b1 || dout !== 32'h2) begin
            bad++;
            $display("FAIL mid_reset tx=%b dout=%h want 1 00000002", tx, dout);
        end
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            total++;
            if (tx !== 1'b1 || dout !== 32'h2) begin
                bad++;
                $display("FAIL mid_quiet cyc=%0d tx=%b dout=%h want 1 00000002", i, tx, dout);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
